// File: rtl/t03_controller_poller.sv
// rtl/t03_controller_poller.sv - polls two serial game controllers into a 16-bit pressed-high word
module t03_controller_poller #(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 416667,
  parameter int BITS        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                data_p1,
  input  logic                data_p2,
  output logic                ctrl_latch,
  output logic                ctrl_pulse,
  output logic [2*BITS-1:0]   controller_inputs,
  output logic                valid,
  output logic                busy
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [DW-1:0] LATCH_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST   = DW'(CLK_DIV - 1);
  localparam logic [2:0]    PULSE_LAST  = 3'(BITS - 2);

  typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;

  state_t            state, stateNext;
  logic [PW-1:0]     periodCnt;
  logic [DW-1:0]     divCnt;
  logic [2:0]        pulseCnt;
  logic [1:0]        syncP1, syncP2;
  logic [BITS-1:0]   shiftP1, shiftP2;
  logic              lastCycle;
  logic              sampleNow;

  always_comb begin
    stateNext = state;
    lastCycle = 1'b0;
    case (state)
      IDLE:  if (periodCnt == '0 && en) stateNext = LATCH;
      LATCH: begin
        lastCycle = (divCnt == LATCH_LAST);
        if (lastCycle) stateNext = HIGH;
      end
      HIGH: begin
        lastCycle = (divCnt == HALF_LAST);
        if (lastCycle) stateNext = LOW;
      end
      LOW: begin
        lastCycle = (divCnt == HALF_LAST);
        if (lastCycle) stateNext = (pulseCnt == PULSE_LAST) ? DONE : HIGH;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Bit 0 is taken at the end of the latch, every later bit at the end of a low phase.
  assign sampleNow = lastCycle && (state == LATCH || state == LOW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periodCnt         <= '0;
      divCnt            <= '0;
      pulseCnt          <= '0;
      syncP1            <= 2'b11;
      syncP2            <= 2'b11;
      shiftP1           <= '0;
      shiftP2           <= '0;
      controller_inputs <= '0;
      ctrl_latch        <= 1'b0;
      ctrl_pulse        <= 1'b0;
      valid             <= 1'b0;
      busy              <= 1'b0;
    end else begin
      periodCnt <= (periodCnt == PERIOD_LAST) ? '0 : periodCnt + PW'(1);
      divCnt    <= (stateNext != state || state == IDLE) ? '0 : divCnt + DW'(1);
      if (state == LATCH)
        pulseCnt <= '0;
      else if (state == LOW && lastCycle)
        pulseCnt <= pulseCnt + 3'd1;
      syncP1 <= {syncP1[0], data_p1};
      syncP2 <= {syncP2[0], data_p2};
      if (sampleNow) begin
        shiftP1 <= {shiftP1[BITS-2:0], ~syncP1[1]};
        shiftP2 <= {shiftP2[BITS-2:0], ~syncP2[1]};
      end
      // The last bit is folded in directly so the word appears on the DONE cycle.
      if (stateNext == DONE)
        controller_inputs <= {shiftP1[BITS-2:0], ~syncP1[1], shiftP2[BITS-2:0], ~syncP2[1]};
      ctrl_latch <= (stateNext == LATCH);
      ctrl_pulse <= (stateNext == HIGH);
      busy       <= (stateNext == LATCH || stateNext == HIGH || stateNext == LOW);
      valid      <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_t03_controller_poller.sv
// tb/tb_t03_controller_poller.sv - randomized self-checking bench for t03_controller_poller
module tb_t03_controller_poller;

  localparam int D      = 4;
  localparam int PERIOD = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        data_p1 = 1'b1;
  logic        data_p2 = 1'b1;
  logic        ctrl_latch, ctrl_pulse, valid, busy;
  logic [15:0] controller_inputs;

  int          total = 0;
  int          bad = 0;
  logic [15:0] lastWord = 16'h0000;
  logic        nextPoll = 1'b0;

  t03_controller_poller #(.CLK_DIV(D), .POLL_PERIOD(PERIOD), .BITS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .data_p1(data_p1), .data_p2(data_p2),
    .ctrl_latch(ctrl_latch), .ctrl_pulse(ctrl_pulse),
    .controller_inputs(controller_inputs), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_latch"}, 16'(ctrl_latch), 16'h0);
    chk({tag, "_pulse"}, 16'(ctrl_pulse), 16'h0);
    chk({tag, "_busy"},  16'(busy), 16'h0);
    chk({tag, "_valid"}, 16'(valid), 16'h0);
    chk({tag, "_word"},  controller_inputs, 16'h0);
  endtask

  // Assert reset mid-cycle with random inputs; outputs must clear without a clock edge.
  task automatic assertReset(input string tag);
    data_p1 = 1'($urandom);
    data_p2 = 1'($urandom);
    en      = 1'($urandom);
    #2 rst = 1'b1;
    #1 checkZero(tag);
    lastWord = 16'h0000;
  endtask

  task automatic releaseReset(input logic enVal);
    @(negedge clk);
    en       = enVal;
    rst      = 1'b0;
    nextPoll = enVal;
  endtask

  // One poll period; pad bit i is held through cycles 2D*i .. 2D*i+2D-1.
  task automatic runWindow(input string tag, input logic [7:0] p1Pad, input logic [7:0] p2Pad,
                           input int enAt, input logic enVal, input int rstAt);
    logic        polled;
    logic [15:0] expWord;
    logic [15:0] wantWord;
    polled = nextPoll;
    for (int i = 0; i < 8; i++) begin
      expWord[15-i] = ~p1Pad[i];
      expWord[7-i]  = ~p2Pad[i];
    end
    for (int c = 0; c < PERIOD; c++) begin
      @(posedge clk);
      #1;
      if (c == enAt) en = enVal;
      if (c < 16 * D) begin
        data_p1 = p1Pad[c / (2 * D)];
        data_p2 = p2Pad[c / (2 * D)];
      end else begin
        data_p1 = 1'($urandom);
        data_p2 = 1'($urandom);
      end
      @(negedge clk);
      wantWord = (polled && c >= 16 * D) ? expWord : lastWord;
      chk({tag, "_latch"}, 16'(ctrl_latch), 16'(polled && c < 2 * D));
      chk({tag, "_pulse"}, 16'(ctrl_pulse),
          16'(polled && c >= 2 * D && c < 16 * D && ((c / D) % 2 == 0)));
      chk({tag, "_busy"},  16'(busy), 16'(polled && c < 16 * D));
      chk({tag, "_valid"}, 16'(valid), 16'(polled && c == 16 * D));
      chk({tag, "_word"},  controller_inputs, wantWord);
      if (c == rstAt) begin
        assertReset({tag, "_rst"});
        return;
      end
    end
    if (polled) lastWord = expWord;
    nextPoll = en;
  endtask

  initial begin
    #3 assertReset("reset");
    releaseReset(1'b0);

    for (int k = 0; k < 5; k++)
      runWindow("en_off", 8'($urandom), 8'($urandom), (k == 4) ? 150 : -1, 1'b1, -1);

    runWindow("full_poll", 8'b1111_1100, 8'b0111_1111, -1, 1'b1, -1);
    runWindow("released",  8'hFF, 8'hFF, -1, 1'b1, -1);
    runWindow("a_only",    8'hFE, 8'hFF, -1, 1'b1, -1);

    for (int k = 0; k < 4; k++)
      runWindow("random", 8'($urandom), 8'($urandom), -1, 1'b1, -1);

    runWindow("en_drop",  8'($urandom), 8'($urandom), 20, 1'b0, -1);
    runWindow("en_idle",  8'($urandom), 8'($urandom), 100, 1'b1, -1);
    runWindow("en_back",  8'($urandom), 8'($urandom), -1, 1'b1, -1);

    runWindow("rst_mid",  8'h00, 8'h5A, -1, 1'b1, 30);
    releaseReset(1'b1);
    runWindow("after_rst", 8'($urandom), 8'($urandom), -1, 1'b1, -1);
    runWindow("random2",   8'($urandom), 8'($urandom), -1, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
